// File: rtl/clk_ctrl_pkg.sv
// Shared types and defaults for the CPU clock controller: FSM state encoding,
// default widths and the burst-length saturation helper.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2,
    HALT  = 2'd3
  } clk_state_t;

  localparam int DIV_WIDTH_DEF  = 24;
  localparam int STEP_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int NUM_BP_DEF     = 2;

  // A burst of zero pulses is meaningless, so the minimum burst is one pulse.
  function automatic logic [31:0] sat_one(input logic [31:0] len);
    sat_one = (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/clk_bp_match.sv
// Combinational address breakpoint comparator array; hit[i] is set when
// breakpoint i is enabled and its address equals the current CPU address.
module clk_bp_match #(
  parameter int NUM_BP     = 2,
  parameter int ADDR_WIDTH = 8
) (
  input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr,
  input  logic [NUM_BP-1:0]            bp_valid,
  input  logic [ADDR_WIDTH-1:0]        cpu_addr,
  output logic [NUM_BP-1:0]            hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      hit[i] = bp_valid[i] && (cpu_addr == bp_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

endmodule

// File: rtl/cpu_clock_controller.sv
// Board-clock CPU clock manager: issues one-cycle enable pulses in free-run,
// N-step burst or breakpoint-halted modes, with status for the probe bus.
module cpu_clock_controller
  import clk_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF,
  parameter int STEP_WIDTH = STEP_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_BP     = NUM_BP_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_auto_en,
  input  logic                         clk_step,
  input  logic [DIV_WIDTH-1:0]         div_value,
  input  logic [STEP_WIDTH-1:0]        burst_len,
  input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr,
  input  logic [NUM_BP-1:0]            bp_valid,
  input  logic                         bp_clear,
  input  logic [ADDR_WIDTH-1:0]        cpu_addr,
  output logic                         clk_en,
  output logic                         clk_toggle,
  output logic [1:0]                   state,
  output logic [NUM_BP-1:0]            halted_bp,
  output logic [31:0]                  tick_count
);

  localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = 1;
  localparam logic [STEP_WIDTH-1:0] STEP_ONE = 1;

  clk_state_t              state_q, state_d;
  logic [DIV_WIDTH-1:0]    div_cnt_q, div_cnt_d;
  logic [STEP_WIDTH-1:0]   remaining_q, remaining_d;
  logic                    skip_bp_q, skip_bp_d;
  logic [NUM_BP-1:0]       halted_bp_q, halted_bp_d;
  logic                    step_q;
  logic                    step_rise;
  logic                    pulse_due;
  logic                    pulse;
  logic                    bp_stop;
  logic [NUM_BP-1:0]       hit;
  logic [STEP_WIDTH-1:0]   burst_init;

  clk_bp_match #(
    .NUM_BP     (NUM_BP),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bp_match (
    .bp_addr  (bp_addr),
    .bp_valid (bp_valid),
    .cpu_addr (cpu_addr),
    .hit      (hit)
  );

  assign step_rise  = clk_step & ~step_q;
  assign pulse_due  = (div_cnt_q >= div_value);
  assign bp_stop    = |(hit & ~{NUM_BP{skip_bp_q}});
  assign burst_init = STEP_WIDTH'(sat_one(32'(burst_len)));

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    remaining_d = remaining_q;
    skip_bp_d   = skip_bp_q;
    halted_bp_d = halted_bp_q;
    pulse       = 1'b0;

    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        if (clk_auto_en) begin
          state_d = RUN;
        end else if (step_rise) begin
          state_d     = BURST;
          remaining_d = burst_init;
        end
      end

      RUN: begin
        if (!clk_auto_en) begin
          state_d   = IDLE;
          div_cnt_d = '0;
        end else if (pulse_due) begin
          div_cnt_d = '0;
          if (bp_stop) begin
            state_d     = HALT;
            halted_bp_d = hit;
          end else begin
            pulse = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_ONE;
        end
      end

      BURST: begin
        if (clk_auto_en) begin
          state_d     = RUN;
          remaining_d = '0;
          div_cnt_d   = '0;
        end else if (pulse_due) begin
          div_cnt_d = '0;
          if (bp_stop) begin
            state_d     = HALT;
            halted_bp_d = hit;
          end else begin
            pulse       = 1'b1;
            remaining_d = remaining_q - STEP_ONE;
            if (remaining_q <= STEP_ONE) state_d = IDLE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_ONE;
        end
      end

      HALT: begin
        div_cnt_d = '0;
        // Clear wins over step; either exit arms the one-shot breakpoint bypass.
        if (bp_clear) begin
          state_d     = IDLE;
          halted_bp_d = '0;
          skip_bp_d   = 1'b1;
        end else if (step_rise) begin
          state_d     = BURST;
          remaining_d = burst_init;
          skip_bp_d   = 1'b1;
          halted_bp_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    if (pulse) skip_bp_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      remaining_q <= '0;
      skip_bp_q   <= 1'b0;
      halted_bp_q <= '0;
      step_q      <= 1'b1;
      clk_en      <= 1'b0;
      clk_toggle  <= 1'b0;
      tick_count  <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      remaining_q <= remaining_d;
      skip_bp_q   <= skip_bp_d;
      halted_bp_q <= halted_bp_d;
      step_q      <= clk_step;
      clk_en      <= pulse;
      clk_toggle  <= clk_toggle ^ pulse;
      tick_count  <= tick_count + {31'd0, pulse};
    end
  end

  assign state     = state_q;
  assign halted_bp = halted_bp_q;

endmodule
